// File: rtl/ddr5_bank_cmd_sequencer.sv
// rtl/ddr5_bank_cmd_sequencer.sv - turns one request at a time into PRE/ACT/RD/WR
// (or PREA/REF for refresh) with open-page row tracking and tRP/tRCD/tCCD/tRFC spacing.
module ddr5_bank_cmd_sequencer #(
  parameter int N_BG   = 8,
  parameter int N_BANK = 4,
  parameter int T_RP   = 4,
  parameter int T_RCD  = 4,
  parameter int T_CCD  = 2,
  parameter int T_RFC  = 10,
  parameter int BG_W   = $clog2(N_BG),
  parameter int BK_W   = $clog2(N_BANK)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [15:0]     req_row_i,
  input  logic [9:0]      req_col_i,
  input  logic [BG_W-1:0] req_bg_i,
  input  logic [BK_W-1:0] req_bank_i,
  input  logic            ref_req_i,
  output logic            ref_ack_o,
  output logic            cmd_valid_o,
  output logic [2:0]      cmd_type_o,
  output logic [BG_W-1:0] cmd_bg_o,
  output logic [BK_W-1:0] cmd_bank_o,
  output logic [15:0]     cmd_row_o,
  output logic [9:0]      cmd_col_o,
  output logic            req_done_o
);

  localparam int NB    = N_BG * N_BANK;
  localparam int BIX_W = $clog2(NB);
  localparam int T_M1  = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_M2  = (T_CCD > T_RFC) ? T_CCD : T_RFC;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int TW    = $clog2(T_MAX) + 1;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD,
    S_COL, S_WAIT_CCD, S_PREA, S_WAIT_RPA, S_REF, S_WAIT_RFC
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NB-1:0]   open_q;
  logic [15:0]     row_tbl_q [NB];

  logic [1:0]      lat_op_q;
  logic [15:0]     lat_row_q;
  logic [9:0]      lat_col_q;
  logic [BG_W-1:0] lat_bg_q;
  logic [BK_W-1:0] lat_bank_q;
  logic [BIX_W-1:0] bidx;

  logic            ready_q, ready_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [2:0]      cmd_type_q, cmd_type_d;
  logic [BG_W-1:0] cmd_bg_q, cmd_bg_d;
  logic [BK_W-1:0] cmd_bank_q, cmd_bank_d;
  logic [15:0]     cmd_row_q, cmd_row_d;
  logic [9:0]      cmd_col_q, cmd_col_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            accept;

  assign bidx        = BIX_W'(lat_bg_q) * BIX_W'(N_BANK) + BIX_W'(lat_bank_q);
  // Refresh gates the handshake immediately so a pending request cannot slip in ahead of it.
  assign req_ready_o = ready_q & ~ref_req_i;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (ref_req_i)   state_d = (|open_q) ? S_PREA : S_REF;
        else if (accept) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (open_q[bidx]) state_d = (row_tbl_q[bidx] == lat_row_q) ? S_COL : S_PRE;
        else              state_d = S_ACT;
      end
      S_PRE: begin
        if (T_RP > 1) begin state_d = S_WAIT_RP; timer_d = TW'(T_RP - 1); end
        else state_d = S_ACT;
      end
      S_ACT: begin
        if (T_RCD > 1) begin state_d = S_WAIT_RCD; timer_d = TW'(T_RCD - 1); end
        else state_d = S_COL;
      end
      S_COL: begin
        if (T_CCD > 1) begin state_d = S_WAIT_CCD; timer_d = TW'(T_CCD - 1); end
        else state_d = S_IDLE;
      end
      S_PREA: begin
        if (T_RP > 1) begin state_d = S_WAIT_RPA; timer_d = TW'(T_RP - 1); end
        else state_d = S_REF;
      end
      S_REF: begin
        if (T_RFC > 1) begin state_d = S_WAIT_RFC; timer_d = TW'(T_RFC - 1); end
        else state_d = S_IDLE;
      end
      S_WAIT_RP, S_WAIT_RCD, S_WAIT_CCD, S_WAIT_RPA, S_WAIT_RFC: begin
        if (timer_q <= TW'(1)) begin
          unique case (state_q)
            S_WAIT_RP:  state_d = S_ACT;
            S_WAIT_RCD: state_d = S_COL;
            S_WAIT_RPA: state_d = S_REF;
            default:    state_d = S_IDLE;
          endcase
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so each command appears in its own state's cycle.
  always_comb begin
    ready_d     = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_type_d  = C_NOP;
    cmd_bg_d    = '0;
    cmd_bank_d  = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    done_d      = 1'b0;
    ack_d       = 1'b0;
    unique case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_PRE: begin
        cmd_valid_d = 1'b1; cmd_type_d = C_PRE;
        cmd_bg_d = lat_bg_q; cmd_bank_d = lat_bank_q;
      end
      S_ACT: begin
        cmd_valid_d = 1'b1; cmd_type_d = C_ACT;
        cmd_bg_d = lat_bg_q; cmd_bank_d = lat_bank_q; cmd_row_d = lat_row_q;
      end
      S_COL: begin
        cmd_valid_d = 1'b1; cmd_type_d = (lat_op_q == 2'd1) ? C_WR : C_RD;
        cmd_bg_d = lat_bg_q; cmd_bank_d = lat_bank_q; cmd_col_d = lat_col_q;
        done_d = 1'b1;
      end
      S_PREA: begin cmd_valid_d = 1'b1; cmd_type_d = C_PREA; end
      S_REF:  begin cmd_valid_d = 1'b1; cmd_type_d = C_REF; ack_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      open_q      <= '0;
      lat_op_q    <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      lat_bg_q    <= '0;
      lat_bank_q  <= '0;
      ready_q     <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= C_NOP;
      cmd_bg_q    <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ready_q     <= ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      if (state_q == S_IDLE && state_d == S_CHECK) begin
        lat_op_q   <= req_op_i;
        lat_row_q  <= req_row_i;
        lat_col_q  <= req_col_i;
        lat_bg_q   <= req_bg_i;
        lat_bank_q <= req_bank_i;
      end
      if (state_d == S_PRE)  open_q[bidx] <= 1'b0;
      if (state_d == S_ACT)  open_q[bidx] <= 1'b1;
      if (state_d == S_PREA) open_q       <= '0;
    end
  end

  // Row contents only matter while the open bit is set, so the table needs no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_d == S_ACT) row_tbl_q[bidx] <= lat_row_q;
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_type_o  = cmd_type_q;
  assign cmd_bg_o    = cmd_bg_q;
  assign cmd_bank_o  = cmd_bank_q;
  assign cmd_row_o   = cmd_row_q;
  assign cmd_col_o   = cmd_col_q;
  assign req_done_o  = done_q;
  assign ref_ack_o   = ack_q;

endmodule
